// File: rtl/rv32_fetch_unit_if.sv
// Fetch-stage bus bundle: redirect input, imem request/response, decode-side instruction stream.
// The master view belongs to the fetch unit; the slave view is the surrounding environment.
interface rv32_fetch_unit_if #(
    parameter int PC_W = 32
);
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [PC_W-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr_data;
    logic [PC_W-1:0] instr_pc;
    logic            fetch_misalign;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
        output imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc, fetch_misalign
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
        input  imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc, fetch_misalign
    );
endinterface

// File: rtl/rv32_fetch_unit.sv
// RV32 fetch stage: owns the fetch PC, issues in-order imem requests under a DEPTH credit limit,
// buffers {pc, word} for decode and drops stale responses after a redirect.
// Optional misaligned-redirect trap enabled by defining RV32_FETCH_MISALIGN_CHK_EN.
module rv32_fetch_unit #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
    parameter int              DEPTH    = 2
) (
    input logic               clk,
    input logic               rst_n,
    rv32_fetch_unit_if.master bus
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W:0]   CNT_LIM  = (CNT_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [PC_W-1:0]  r_pc, w_pc_nxt;
    logic [CNT_W-1:0] r_out, w_out_nxt;
    logic [CNT_W-1:0] r_drop, w_drop_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [PTR_W-1:0] r_wr, w_wr_nxt, r_rd, w_rd_nxt;
    logic [PTR_W-1:0] r_pq_wr, r_pq_rd;
    logic [PC_W-1:0]  r_pq    [DEPTH];
    logic [PC_W-1:0]  r_fpc   [DEPTH];
    logic [31:0]      r_fdata [DEPTH];
    logic             r_misalign, w_misalign_nxt;
    logic             w_accept, w_rsp, w_push, w_pop, w_ivld, w_bad_redir;
    logic [PC_W-1:0]  w_redir_pc;

`ifdef RV32_FETCH_MISALIGN_CHK_EN
    assign w_bad_redir = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
    assign w_redir_pc  = bus.redirect_pc;
`else
    assign w_bad_redir = 1'b0;
    assign w_redir_pc  = bus.redirect_pc & ~PC_W'(2'b11);
`endif

    // A response with nothing outstanding is a protocol error and is ignored entirely.
    assign w_rsp    = bus.imem_rsp_valid && (r_out != CNT_ZERO);
    assign w_accept = bus.imem_req_valid && bus.imem_req_ready;
    assign w_ivld   = (r_cnt != CNT_ZERO);
    assign w_push   = w_rsp && (r_drop == CNT_ZERO) && !bus.redirect_valid;
    assign w_pop    = w_ivld && bus.instr_ready && !bus.redirect_valid;

    assign bus.imem_req_valid = (r_state != S_BOOT) && !bus.redirect_valid && !r_misalign &&
                                (({1'b0, r_out} + {1'b0, r_cnt}) < CNT_LIM);
    assign bus.imem_req_addr  = r_pc;
    assign bus.instr_valid    = w_ivld;
    assign bus.instr_data     = w_ivld ? r_fdata[r_rd] : 32'h0000_0000;
    assign bus.instr_pc       = w_ivld ? r_fpc[r_rd] : {PC_W{1'b0}};
    assign bus.fetch_misalign = r_misalign;

    // Next-value logic for PC, credit counters and FIFO pointers; redirect overrides everything.
    always_comb begin
        w_pc_nxt       = r_pc;
        w_drop_nxt     = r_drop;
        w_cnt_nxt      = r_cnt;
        w_wr_nxt       = r_wr;
        w_rd_nxt       = r_rd;
        w_misalign_nxt = r_misalign;
        w_out_nxt      = r_out + CNT_W'(w_accept) - CNT_W'(w_rsp);
        if (bus.redirect_valid) begin
            w_drop_nxt = r_out - CNT_W'(w_rsp);
            w_cnt_nxt  = CNT_ZERO;
            w_wr_nxt   = {PTR_W{1'b0}};
            w_rd_nxt   = {PTR_W{1'b0}};
            if (w_bad_redir) begin
                w_misalign_nxt = 1'b1;
            end else begin
                w_pc_nxt = w_redir_pc;
            end
        end else begin
            w_drop_nxt = r_drop - CNT_W'(w_rsp && (r_drop != CNT_ZERO));
            w_cnt_nxt  = r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
            w_wr_nxt   = r_wr + PTR_W'(w_push);
            w_rd_nxt   = r_rd + PTR_W'(w_pop);
            if (w_accept) begin
                w_pc_nxt = r_pc + PC_W'(3'd4);
            end else begin
                w_pc_nxt = r_pc;
            end
        end
    end

    // Control FSM next state: FLUSH while stale responses remain to be dropped.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_BOOT:  w_state_nxt = (w_drop_nxt != CNT_ZERO) ? S_FLUSH : S_RUN;
            S_RUN: begin
                if (bus.redirect_valid && (w_drop_nxt != CNT_ZERO)) begin
                    w_state_nxt = S_FLUSH;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_FLUSH: begin
                if (w_drop_nxt == CNT_ZERO) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_FLUSH;
                end
            end
            default: w_state_nxt = S_BOOT;
        endcase
    end

    // State, counter and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_PC;
            r_out      <= CNT_ZERO;
            r_drop     <= CNT_ZERO;
            r_cnt      <= CNT_ZERO;
            r_wr       <= {PTR_W{1'b0}};
            r_rd       <= {PTR_W{1'b0}};
            r_pq_wr    <= {PTR_W{1'b0}};
            r_pq_rd    <= {PTR_W{1'b0}};
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_out      <= w_out_nxt;
            r_drop     <= w_drop_nxt;
            r_cnt      <= w_cnt_nxt;
            r_wr       <= w_wr_nxt;
            r_rd       <= w_rd_nxt;
            r_pq_wr    <= r_pq_wr + PTR_W'(w_accept);
            r_pq_rd    <= r_pq_rd + PTR_W'(w_rsp);
            r_misalign <= w_misalign_nxt;
        end
    end

    // Storage: PC of every outstanding request, and the decode FIFO entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pq[i]    <= {PC_W{1'b0}};
                r_fpc[i]   <= {PC_W{1'b0}};
                r_fdata[i] <= 32'h0000_0000;
            end
        end else begin
            if (w_accept) begin
                r_pq[r_pq_wr] <= r_pc;
            end
            if (w_push) begin
                r_fpc[r_wr]   <= r_pq[r_pq_rd];
                r_fdata[r_wr] <= bus.imem_rsp_data;
            end
        end
    end
endmodule

// File: doc/rv32_fetch_unit.md
Name: rv32_fetch_unit

Overview:
- PC register and instruction-fetch stage. Sits directly downstream of rv32_next_pc and consumes its redirect outputs (rv32_has_new_pc / rv32_next_pc_val, or csr_irq_evt.valid).
- Owns the architectural fetch PC and issues in-order requests to instruction memory over a valid/ready handshake.
- Buffers returned words with their PCs in a small FIFO for decode.
- Discards in-flight responses made stale by a redirect.

Parameters:
- PC_W, 32: width of PC and fetch address.
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- DEPTH, 2: instruction FIFO depth; also the limit on outstanding fetches plus buffered entries. Power of 2, ≥2.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- redirect_valid, input, 1: new-PC request. Driven by rv32_has_new_pc OR irq valid.
- redirect_pc, input, PC_W: target PC (rv32_next_pc_val).
- imem_req_valid, output, 1: fetch request valid.
- imem_req_ready, input, 1: memory accepts request.
- imem_req_addr, output, PC_W: fetch address.
- imem_rsp_valid, input, 1: response word valid. In order, no backpressure.
- imem_rsp_data, input, 32: response instruction.
- instr_valid, output, 1: FIFO head valid.
- instr_ready, input, 1: decode accepts head.
- instr_data, output, 32: head instruction.
- instr_pc, output, PC_W: PC of head instruction.
- fetch_misalign, output, 1: optional; see Optional Feature.

Behaviour:

Reset:
- Asserting rst_n low asynchronously sets: pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, state=BOOT.
- Output values during reset: imem_req_valid=0, instr_valid=0, instr_data=0, instr_pc=0, fetch_misalign=0.
- Reset mid-transaction abandons all in-flight requests. Responses arriving after release are ignored because outstanding=0.

State machine:
- BOOT: one cycle after reset release with no request issued, then RUN.
- RUN: normal operation.
- FLUSH: entered on a redirect while drop_cnt>0 after the update. Returns to RUN when drop_cnt reaches 0. Requests may still issue in FLUSH.

Request issue:
- imem_req_valid = (state!=BOOT) && !redirect_valid && (outstanding + fifo_count < DEPTH).
- imem_req_addr = pc.
- On imem_req_valid && imem_req_ready: pc <= pc+4 (modulo 2^PC_W, wraps to 0), outstanding++, pc pushed into internal PC queue (depth DEPTH).
- Address is held stable while valid && !ready.

Response:
- On imem_rsp_valid: outstanding--.
- If drop_cnt>0: drop_cnt--, word discarded, PC queue popped.
- Else: {PC queue head, data} pushed into FIFO. The credit rule guarantees space.
- A response with outstanding=0 is a protocol error; it is ignored.

Output:
- FIFO head is presented combinationally; instr_valid = !empty.
- Pop on instr_valid && instr_ready.
- Same-cycle push and pop are allowed when full or empty. Empty bypass is not allowed: minimum latency from request accept to instr_valid is response latency + 1 cycle.

Redirect (highest priority):
- pc <= redirect_pc.
- FIFO flushed. An instr_ready pop in the same cycle is ignored.
- drop_cnt <= outstanding − (imem_rsp_valid ? 1 : 0) + drop_cnt_adjust; net result is that all currently outstanding responses get dropped.
- No request is issued in the redirect cycle.
- First fetch at redirect_pc is issued the next cycle.
- Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- A redirect in BOOT loads pc; BOOT still completes.

Optional Feature:
- Macro: RV32_FETCH_MISALIGN_CHK_EN.
- Enabled:
  - A redirect with redirect_pc[1:0]!=0 does not load pc.
  - It sets fetch_misalign=1 (registered, sticky until reset), flushes the FIFO and sets drop_cnt as for a normal redirect.
  - Fetching halts (imem_req_valid=0) until reset.
- Disabled:
  - fetch_misalign is tied 0.
  - redirect_pc[1:0] is forced to 0 when loaded into pc.

Test Plan:
- Reset with RESET_PC=0x100, imem_req_ready=1, response latency 1 → requests at 0x100, 0x104, 0x108…; first instr_valid with instr_pc=0x100 three cycles after reset release.
- instr_ready=0 held → at most DEPTH=2 requests issued, FIFO full, imem_req_valid=0; release ready → flow resumes with no lost or duplicated PCs.
- Two fetches outstanding (0x200, 0x204), redirect_pc=0x400 → both responses dropped, FIFO empty, next instr_pc=0x400.
- imem_req_ready=0 for 3 cycles → imem_req_addr stable at 0x10C; pc advances only on the accept cycle.
- pc=0xFFFF_FFFC accepted → next request at 0x0000_0000.
- Macro enabled, redirect_pc=0x402 → fetch_misalign=1, imem_req_valid=0 thereafter. Macro disabled, same stimulus → fetch resumes at 0x400.
